pg_domain_sequencer: RTL
========================

Name: pg_domain_sequencer

Overview:
- Power-management scheduler for N power-gated domains, each controlled by its own power-gating FSM (en input, status output).
- Watches per-domain activity and deasserts a domain's FSM en after a programmable idle time.
- Re-powers domains on wake request.
- Only one domain may be in the power-up (inrush) sequence at a time; pending power-ups are granted round-robin.

Parameters:
- N_DOM, 4, number of domains/FSMs managed.
- ID_W, 2, width of grant_id (ceil(log2(N_DOM)), minimum 1).
- CNT_W, 16, width of the idle counter and idle_thresh.

Ports:
- ck  in  1  clock
- rst  in  1  asynchronous active-high reset
- idle_thresh  in  CNT_W  idle cycles before power-down, shared by all domains; 0 disables power-down
- busy  in  N_DOM  domain i has activity this cycle
- wake_req  in  N_DOM  work pending for domain i, level
- fsm_status  in  N_DOM  status output of domain i's power-gating FSM (1 = on)
- fsm_en  out  N_DOM  en input of domain i's FSM (1 = stay/go on)
- dom_ready  out  N_DOM  domain i is in ON and usable
- pwr_up_busy  out  1  the power-up slot is occupied
- grant_id  out  ID_W  index of the last-granted power-up domain

Behaviour:
- Clocking and reset: one clock, ck. Reset is asynchronous and active-high on rst. All state and outputs are registered.
- Reset values:
  - every domain in state ON
  - fsm_en = all 1
  - dom_ready = all 1
  - idle counters = 0
  - pwr_up_busy = 0
  - grant_id = 0
  - round-robin pointer gives domain 0 highest priority
- Per-domain states: ON, DOWN, OFF, UP_PEND, UP.
- Outputs per state:
  - fsm_en = 1 in ON and UP; 0 in DOWN, OFF and UP_PEND.
  - dom_ready = 1 only in ON.
- Idle counter, ON state only:
  - Clears to 0 on any edge where busy[i] or wake_req[i] is sampled 1.
  - Otherwise increments, saturating at idle_thresh.
  - Held at 0 in all other states.
- ON -> DOWN: at the edge where counter == idle_thresh, idle_thresh != 0, and busy[i] = wake_req[i] = 0. This equals idle_thresh+1 consecutive idle samples.
- DOWN -> OFF: on the edge where fsm_status[i] is sampled 0.
  - The FSM keeps status = 1 for several cycles during its save sequence; DOWN holds fsm_en = 0 throughout.
  - wake_req is ignored in DOWN; power-down always completes.
- OFF -> UP_PEND: on the edge where wake_req[i] = 1. busy is ignored outside ON.
- UP_PEND -> UP: when granted.
- Arbitration:
  - A grant is made on an edge where pwr_up_busy = 0 and at least one domain is in UP_PEND.
  - The winner is the first UP_PEND index at or after the pointer, searching with wrap-around.
  - At that edge: winner -> UP, pwr_up_busy <= 1, grant_id <= winner, pointer <= winner+1 mod N_DOM.
  - At most one grant per edge.
- UP -> ON: on the edge where fsm_status[i] is sampled 1. The FSM only reports 1 once back in its idle-on state.
  - That same edge: pwr_up_busy <= 0, idle counter = 0.
  - The next grant is made no earlier than the following edge. The slot is never granted in the same edge it is released.
- Simultaneous events:
  - Several domains may be DOWN concurrently; power-down is not arbitrated.
  - A domain going DOWN in the same edge as another's grant is legal.
- Mid-operation reset: every domain returns to ON with fsm_en = 1, and any slot or pending grant is dropped. The FSMs share rst and return to their on state.
- idle_thresh may change at any time. The new value applies to the next compare; saturation uses the current value.

Test Plan:
- Reset, then idle_thresh=3 with busy[0]=1 for 5 cycles then 0, other domains busy -> fsm_en[0] falls after the 4th idle edge; dom_ready[0]=0 from the same edge; other bits stay 1.
- Domain 0 in DOWN, fsm_status[0] held 1 for 10 cycles then 0, wake_req[0] pulsed during DOWN -> state stays DOWN and fsm_en[0]=0 throughout; OFF entered on the edge after status drops; the wake pulse is lost.
- Domains 0, 2, 3 OFF with wake_req raised in the same cycle, pointer=0 -> grants in order 0, 2, 3; each grant only after the previous domain's fsm_status returns 1; pwr_up_busy has a 1-cycle low gap between grants; grant_id = 0, 2, 3.
- Pointer at 3 after granting domain 2, then wake_req on domains 1 and 3 -> domain 3 granted before 1.
- idle_thresh=0, all inputs idle for 1000 cycles -> fsm_en stays all 1 and no state change.
- Assert rst while domain 1 is in UP with pwr_up_busy=1 -> immediately fsm_en=all 1, dom_ready=all 1, pwr_up_busy=0, grant_id=0.

Source files
------------

// File: rtl/pg_domain_sequencer.sv
// pg_domain_sequencer: idle-timed power-down and single-slot round-robin power-up of N_DOM gated domains
// Ports: ck/rst clock and async active-high reset; idle_thresh idle cycles before power-down (0 = never);
//   busy/wake_req per-domain activity and pending-work level; fsm_status per-domain FSM status (1 = on);
//   fsm_en per-domain FSM enable; dom_ready domain on and usable; pwr_up_busy power-up slot occupied;
//   grant_id index of the last domain granted the power-up slot.
module pg_domain_sequencer #(
    parameter int N_DOM = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [CNT_W-1:0] idle_thresh,
    input  logic [N_DOM-1:0] busy,
    input  logic [N_DOM-1:0] wake_req,
    input  logic [N_DOM-1:0] fsm_status,
    output logic [N_DOM-1:0] fsm_en,
    output logic [N_DOM-1:0] dom_ready,
    output logic             pwr_up_busy,
    output logic [ID_W-1:0]  grant_id
);
    typedef enum logic [2:0] {ON, DOWN, OFF, UP_PEND, UP} st_t;
    st_t              st_q [N_DOM];
    st_t              st_d [N_DOM];
    logic [CNT_W-1:0] cnt_q [N_DOM];
    logic [CNT_W-1:0] cnt_d [N_DOM];
    logic [N_DOM-1:0] en_q, en_d, rdy_q, rdy_d;
    logic [ID_W-1:0]  ptr_q, ptr_d, gid_q, gid_d, win;
    logic             pub_q, pub_d, found, gnt, rel;
    int               idx;
    // Round-robin search: first UP_PEND domain at or after the pointer, with wrap-around.
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 0; k < N_DOM; k++) begin
            idx = (int'(ptr_q) + k) % N_DOM;
            if (!found && st_q[idx] == UP_PEND) begin
                found = 1'b1;
                win = ID_W'(idx);
            end
        end
        // The slot is only granted while free, so a release and a grant never share an edge.
        gnt = found && !pub_q;
    end
    always_comb begin
        rel = 1'b0;
        for (int i = 0; i < N_DOM; i++) begin
            st_d[i] = st_q[i];
            cnt_d[i] = '0;
            case (st_q[i])
                ON: begin
                    if (busy[i] || wake_req[i])
                        cnt_d[i] = '0;
                    else if (idle_thresh != '0 && cnt_q[i] == idle_thresh)
                        st_d[i] = DOWN;
                    else
                        cnt_d[i] = (cnt_q[i] >= idle_thresh) ? idle_thresh : cnt_q[i] + 1'b1;
                end
                DOWN:    st_d[i] = fsm_status[i] ? DOWN : OFF;
                OFF:     st_d[i] = wake_req[i] ? UP_PEND : OFF;
                UP_PEND: st_d[i] = (gnt && int'(win) == i) ? UP : UP_PEND;
                UP: begin
                    st_d[i] = fsm_status[i] ? ON : UP;
                    rel = rel | fsm_status[i];
                end
                default: st_d[i] = ON;
            endcase
            en_d[i] = (st_d[i] == ON) || (st_d[i] == UP);
            rdy_d[i] = (st_d[i] == ON);
        end
        pub_d = gnt || (pub_q && !rel);
        gid_d = gnt ? win : gid_q;
        ptr_d = gnt ? ((win == ID_W'(N_DOM - 1)) ? '0 : win + 1'b1) : ptr_q;
    end
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DOM; i++) begin
                st_q[i] <= ON;
                cnt_q[i] <= '0;
            end
            en_q <= '1;
            rdy_q <= '1;
            pub_q <= 1'b0;
            gid_q <= '0;
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < N_DOM; i++) begin
                st_q[i] <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            en_q <= en_d;
            rdy_q <= rdy_d;
            pub_q <= pub_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
        end
    end
    assign fsm_en = en_q;
    assign dom_ready = rdy_q;
    assign pwr_up_busy = pub_q;
    assign grant_id = gid_q;
endmodule
